wb_grf: RTL



---
 rtl/wb_grf_pkg.sv | 29 ++
 rtl/wb_grf_sel.sv | 37 +++
 rtl/wb_grf.sv | 79 +++++++
 3 files changed

// File: rtl/wb_grf_pkg.sv
// Shared constants for the writeback stage and register file (wb_grf).
// The writeback-select encoding is also used by the controller.
package wb_grf_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_CNT  = 32;
    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [4:0]  REG_RA   = 5'd31;
    localparam int unsigned LINK_OFF = 8;

    typedef enum logic [2:0] {
        WB_ALU  = 3'd0,
        WB_MEM  = 3'd1,
        WB_RORI = 3'd2,
        WB_LUI  = 3'd3,
        WB_LINK = 3'd4
    } wb_sel_e;

    // Fixed priority: jal > lui > ori > mem > alu.
    function automatic wb_sel_e wb_sel_encode(input logic jal, input logic lui,
                                              input logic ori, input logic mem);
        if (jal)      return WB_LINK;
        else if (lui) return WB_LUI;
        else if (ori) return WB_RORI;
        else if (mem) return WB_MEM;
        else          return WB_ALU;
    endfunction

endpackage

// File: rtl/wb_grf_sel.sv
// Writeback data selector: pure combinational priority mux feeding the GRF.
module wb_sel
    import wb_grf_pkg::*;
#(
    parameter int unsigned DATA_W   = wb_grf_pkg::DATA_W,
    parameter int unsigned LINK_OFF = wb_grf_pkg::LINK_OFF
) (
    input  logic              jal_w,
    input  logic              lui_w,
    input  logic              ori_w,
    input  logic              mem_to_reg_w,
    input  logic [DATA_W-1:0] pc_w,
    input  logic [DATA_W-1:0] hi_imm_w,
    input  logic [DATA_W-1:0] rori_w,
    input  logic [DATA_W-1:0] read_data_w,
    input  logic [DATA_W-1:0] alu_out_w,
    output logic [DATA_W-1:0] wd
);

    wb_sel_e           w_sel;
    logic [DATA_W-1:0] w_link;

    assign w_sel  = wb_sel_encode(jal_w, lui_w, ori_w, mem_to_reg_w);
    assign w_link = pc_w + DATA_W'(LINK_OFF);

    always_comb begin
        wd = alu_out_w;
        case (w_sel)
            WB_LINK: wd = w_link;
            WB_LUI:  wd = hi_imm_w;
            WB_RORI: wd = rori_w;
            WB_MEM:  wd = read_data_w;
            default: wd = alu_out_w;
        endcase
    end

endmodule

// File: rtl/wb_grf.sv
// Writeback stage plus 32x32 general register file with commit logging.
// Optional macro GRF_BYPASS_EN enables same-cycle write-through on rd1/rd2.
module wb_grf
    import wb_grf_pkg::*;
#(
    parameter int unsigned DATA_W   = wb_grf_pkg::DATA_W,
    parameter int unsigned LINK_OFF = wb_grf_pkg::LINK_OFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write_w,
    input  logic              mem_to_reg_w,
    input  logic [DATA_W-1:0] read_data_w,
    input  logic [DATA_W-1:0] alu_out_w,
    input  logic [4:0]        write_reg_w,
    input  logic [DATA_W-1:0] pc_w,
    input  logic              lui_w,
    input  logic [DATA_W-1:0] hi_imm_w,
    input  logic              ori_w,
    input  logic [DATA_W-1:0] rori_w,
    input  logic              jal_w,
    input  logic [4:0]        a1,
    input  logic [4:0]        a2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] wd_w
);

    logic [DATA_W-1:0] r_regs [REG_CNT];
    logic [DATA_W-1:0] w_wd;
    logic              w_we;
    logic [DATA_W-1:0] w_rd1_store;
    logic [DATA_W-1:0] w_rd2_store;

    wb_sel #(
        .DATA_W   (DATA_W),
        .LINK_OFF (LINK_OFF)
    ) u_wb_sel (
        .jal_w        (jal_w),
        .lui_w        (lui_w),
        .ori_w        (ori_w),
        .mem_to_reg_w (mem_to_reg_w),
        .pc_w         (pc_w),
        .hi_imm_w     (hi_imm_w),
        .rori_w       (rori_w),
        .read_data_w  (read_data_w),
        .alu_out_w    (alu_out_w),
        .wd           (w_wd)
    );

    assign wd_w = w_wd;
    assign w_we = reg_write_w && (write_reg_w != REG_ZERO);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < REG_CNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[write_reg_w] <= w_wd;
`ifndef SYNTHESIS
            $display("@%h: $%d <= %h", pc_w, write_reg_w, w_wd);
`endif
        end
    end

    assign w_rd1_store = (a1 == REG_ZERO) ? '0 : r_regs[a1];
    assign w_rd2_store = (a2 == REG_ZERO) ? '0 : r_regs[a2];

`ifdef GRF_BYPASS_EN
    // w_we already excludes $0, so a bypass never leaks a nonzero value onto $0.
    assign rd1 = (w_we && (a1 == write_reg_w)) ? w_wd : w_rd1_store;
    assign rd2 = (w_we && (a2 == write_reg_w)) ? w_wd : w_rd2_store;
`else
    assign rd1 = w_rd1_store;
    assign rd2 = w_rd2_store;
`endif

endmodule
